// File: rtl/multdiv_pkg.sv
// multdiv_pkg
// Shared definitions for the iterative multiply/divide unit:
//   WIDTH   - operand/result width
//   ITERS   - number of shift-add / restoring-divide iterations
//   CNT_W   - iteration counter width (holds ITERS)
//   INT_MIN - most negative WIDTH-bit value
//   state_t - control FSM states
//   magnitude() - absolute value of a two's-complement operand, read as unsigned
package multdiv_pkg;

  localparam int WIDTH = 32;
  localparam int ITERS = WIDTH;
  localparam int CNT_W = 6;

  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // INT_MIN maps to itself, which is its correct magnitude when read unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value);
    return value[WIDTH-1] ? -value : value;
  endfunction

endpackage

// File: rtl/multdiv_counter.sv
// multdiv_counter
// Iteration counter for the multiply/divide FSM.
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous active-high reset
//   clear  - synchronous clear (new operation accepted)
//   enable - advance by one (one datapath iteration performed)
//   count  - current iteration count
//   done   - count has reached TERMINAL
module multdiv_counter
  import multdiv_pkg::*;
#(
  parameter int BITS     = CNT_W,
  parameter int TERMINAL = ITERS
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  output logic [BITS-1:0] count,
  output logic            done
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + BITS'(1);
    end
  end

  assign done = (count == BITS'(TERMINAL));

endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit
// Iterative signed multiply (shift-add) / divide (restoring) unit feeding the
// register file write port. Operands are processed as magnitudes; the sign is
// applied when the result is registered, 33 cycles after the start edge.
// Ports:
//   clock, ctrl_reset             - clock and asynchronous active-high reset
//   ctrl_MULT, ctrl_DIV           - one-cycle start pulses (both high = multiply)
//   data_operandA, data_operandB  - signed operands, latched at start
//   ctrl_dstReg                   - destination tag, latched at start
//   data_result, data_exception   - registered result and overflow/div-by-zero flag
//   data_resultRDY                - one-cycle writeback strobe
//   data_dstReg                   - tag belonging to data_result
//   busy                          - operation in flight
// Optional build macro: MULTDIV_EARLY_OUT_EN finishes a multiply with a zero
// operand, or a divide of zero by a nonzero divisor, one edge after start.
module multdiv_unit
  import multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [4:0]       ctrl_dstReg,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic [4:0]       data_dstReg,
  output logic             busy
);

`ifdef MULTDIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  state_t state, state_next;

  // acc: multiply = {partial product, remaining multiplier bits};
  //      divide   = {partial remainder, dividend bits / quotient bits}.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   oper;
  logic               negate;
  logic [4:0]         tag;

  logic [CNT_W-1:0] count;
  logic             count_done;
  logic             start;
  logic             step;
  logic             finish;
  logic             early;
  logic             early_zero;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     prod_top;
  logic               mul_exc;
  logic [WIDTH-1:0]   quot;
  logic               div_exc;
  logic [WIDTH-1:0]   fin_result;
  logic               fin_exc;

  assign start = ctrl_MULT | ctrl_DIV;

  multdiv_counter #(
    .BITS     (CNT_W),
    .TERMINAL (ITERS)
  ) u_counter (
    .clock  (clock),
    .reset  (ctrl_reset),
    .clear  (start),
    .enable (step),
    .count  (count),
    .done   (count_done)
  );

  // Only meaningful while the counter is still 0, i.e. before any iteration.
  assign early_zero = (state == MUL) ? ((oper == '0) || (acc[WIDTH-1:0] == '0))
                                     : ((acc[WIDTH-1:0] == '0) && (oper != '0));

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A start in any state wins, so an in-flight operation is silently dropped.
  always_comb begin
    state_next     = state;
    step           = 1'b0;
    finish         = 1'b0;
    early          = 1'b0;
    busy           = 1'b0;
    data_resultRDY = 1'b0;
    case (state)
      IDLE: begin
        state_next = IDLE;
      end
      MUL, DIV: begin
        busy = 1'b1;
        if (count_done) begin
          finish     = 1'b1;
          state_next = DONE;
        end else if (EARLY_OUT && (count == '0) && early_zero) begin
          finish     = 1'b1;
          early      = 1'b1;
          state_next = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        data_resultRDY = 1'b1;
        state_next     = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (start) begin
      state_next = ctrl_MULT ? MUL : DIV;
      step       = 1'b0;
      finish     = 1'b0;
      early      = 1'b0;
    end
  end

  // One iteration of each algorithm plus the signed completion values.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, oper} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    div_diff = {1'b0, acc[2*WIDTH-2:WIDTH-1]} - {1'b0, oper};
    div_next = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    // Product fits in WIDTH bits only when the top WIDTH+1 bits all match.
    prod     = negate ? -acc : acc;
    prod_top = prod[2*WIDTH-1:WIDTH-1];
    mul_exc  = ~((&prod_top) | (~|prod_top));

    // A positive quotient of magnitude 2^(WIDTH-1) only arises from INT_MIN / -1.
    quot    = negate ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    div_exc = (oper == '0) || ((acc[WIDTH-1:0] == INT_MIN) && !negate);

    fin_result = '0;
    fin_exc    = 1'b0;
    if (!early) begin
      if (state == MUL) begin
        fin_result = prod[WIDTH-1:0];
        fin_exc    = mul_exc;
      end else begin
        fin_result = (oper == '0) ? '0 : quot;
        fin_exc    = div_exc;
      end
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      acc            <= '0;
      oper           <= '0;
      negate         <= 1'b0;
      tag            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_dstReg    <= '0;
    end else begin
      if (start) begin
        negate <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        tag    <= ctrl_dstReg;
        if (ctrl_MULT) begin
          acc  <= {{WIDTH{1'b0}}, magnitude(data_operandB)};
          oper <= magnitude(data_operandA);
        end else begin
          acc  <= {{WIDTH{1'b0}}, magnitude(data_operandA)};
          oper <= magnitude(data_operandB);
        end
      end else if (step) begin
        acc <= (state == MUL) ? mul_next : div_next;
      end
      if (finish) begin
        data_result    <= fin_result;
        data_exception <= fin_exc;
        data_dstReg    <= tag;
      end
    end
  end

endmodule
